// File: rtl/vx_perf_csr_reader_pkg.sv
// ---------------------------------------------------------------------------
// vx_perf_csr_reader_pkg
//   Shared definitions for the pipeline performance-counter CSR reader:
//   CSR window base addresses, counter index map, response FSM state enum and
//   a small address-window decode helper.
//
//   Counter index map (relative to the lo/hi window base):
//     3 sched_idles, 4 sched_stalls, 5 ibf_stalls, 6 scb_stalls,
//     7 .. 7+NUM_EX-1            units_uses
//     next NUM_SFU entries       sfu_uses
//     then (tail, in order)      ifetches, loads, stores, ifetch_latency,
//                                load_latency, active_warp_cycles,
//                                stalled_warp_cycles
//   The tail position depends on NUM_EX/NUM_SFU, so the tail entries are
//   given as offsets from the first index after sfu_uses.
// ---------------------------------------------------------------------------
package vx_perf_csr_reader_pkg;

    // CSR windows: 0xB00+idx returns bits [31:0], 0xB80+idx returns [63:32].
    localparam logic [11:0] CSR_BASE_LO = 12'hB00;
    localparam logic [11:0] CSR_BASE_HI = 12'hB80;

    // Low address bits carry the counter index; the rest select the window.
    localparam int IDX_W = 7;

    localparam int IDX_SCHED_IDLES  = 3;
    localparam int IDX_SCHED_STALLS = 4;
    localparam int IDX_IBF_STALLS   = 5;
    localparam int IDX_SCB_STALLS   = 6;
    localparam int IDX_UNITS_BASE   = 7;

    localparam int OFS_IFETCHES            = 0;
    localparam int OFS_LOADS               = 1;
    localparam int OFS_STORES              = 2;
    localparam int OFS_IFETCH_LATENCY      = 3;
    localparam int OFS_LOAD_LATENCY        = 4;
    localparam int OFS_ACTIVE_WARP_CYCLES  = 5;
    localparam int OFS_STALLED_WARP_CYCLES = 6;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } csr_state_e;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_LO   = 2'd1,
        WIN_HI   = 2'd2
    } csr_win_e;

    // Both windows are 128 entries wide and 128-aligned, so a compare of the
    // upper address bits is enough to classify an address.
    function automatic csr_win_e csr_window(input logic [11:0] addr);
        if (addr[11:IDX_W] == CSR_BASE_LO[11:IDX_W]) begin
            return WIN_LO;
        end
        if (addr[11:IDX_W] == CSR_BASE_HI[11:IDX_W]) begin
            return WIN_HI;
        end
        return WIN_NONE;
    endfunction

endpackage

// File: rtl/vx_perf_pipeline_if.sv
// ---------------------------------------------------------------------------
// vx_perf_pipeline_if
//   Bundle of pipeline performance counters produced by the core plus the
//   per-cycle warp masks used to build the warp-cycle accumulators.
//
//   Signals:
//     sched_idles, sched_stalls, ibf_stalls, scb_stalls   CTR_W counters
//     units_uses[NUM_EX], sfu_uses[NUM_SFU]               CTR_W counters
//     ifetches, loads, stores                             CTR_W counters
//     ifetch_latency, load_latency                        CTR_W counters
//     active_warps_n, stalled_warps_n                     NUM_WARPS masks
//
//   Modports: master (producer), slave (CSR reader).
// ---------------------------------------------------------------------------
interface vx_perf_pipeline_if #(
    parameter int CTR_W     = 44,
    parameter int NUM_EX    = 3,
    parameter int NUM_SFU   = 2,
    parameter int NUM_WARPS = 4
);
    logic [CTR_W-1:0]               sched_idles;
    logic [CTR_W-1:0]               sched_stalls;
    logic [CTR_W-1:0]               ibf_stalls;
    logic [CTR_W-1:0]               scb_stalls;
    logic [NUM_EX-1:0][CTR_W-1:0]   units_uses;
    logic [NUM_SFU-1:0][CTR_W-1:0]  sfu_uses;
    logic [CTR_W-1:0]               ifetches;
    logic [CTR_W-1:0]               loads;
    logic [CTR_W-1:0]               stores;
    logic [CTR_W-1:0]               ifetch_latency;
    logic [CTR_W-1:0]               load_latency;
    logic [NUM_WARPS-1:0]           active_warps_n;
    logic [NUM_WARPS-1:0]           stalled_warps_n;

    modport master (
        output sched_idles, sched_stalls, ibf_stalls, scb_stalls,
               units_uses, sfu_uses, ifetches, loads, stores,
               ifetch_latency, load_latency, active_warps_n, stalled_warps_n
    );

    modport slave (
        input  sched_idles, sched_stalls, ibf_stalls, scb_stalls,
               units_uses, sfu_uses, ifetches, loads, stores,
               ifetch_latency, load_latency, active_warps_n, stalled_warps_n
    );
endinterface

// File: rtl/vx_perf_csr_reader_accum.sv
// ---------------------------------------------------------------------------
// vx_perf_accum
//   Saturating popcount accumulator: every cycle adds the number of set bits
//   in mask to a CTR_W-wide count. The count sticks at all-ones instead of
//   wrapping. The count output is the registered value, so a reader sampling
//   it in the same cycle as an update sees the pre-update value.
//
//   Ports:
//     clk    in   1          clock
//     rst_n  in   1          asynchronous active-low reset (count -> 0)
//     mask   in   NUM_WARPS  per-cycle warp mask
//     count  out  CTR_W      accumulated warp-cycles
// ---------------------------------------------------------------------------
module vx_perf_accum #(
    parameter int CTR_W     = 44,
    parameter int NUM_WARPS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_WARPS-1:0] mask,
    output logic [CTR_W-1:0]     count
);

    localparam int CNT_W = $clog2(NUM_WARPS + 1);

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_WARPS-1:0] m);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            cnt = cnt + CNT_W'(m[i]);
        end
        return cnt;
    endfunction

    // One extra bit catches the carry out of the counter; on carry the
    // result clamps to all-ones.
    function automatic logic [CTR_W-1:0] sat_add(input logic [CTR_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CTR_W:0] sum;
        sum = {1'b0, a} + (CTR_W+1)'(b);
        return sum[CTR_W] ? {CTR_W{1'b1}} : sum[CTR_W-1:0];
    endfunction

    logic [CNT_W-1:0] pop_p0;
    logic [CTR_W-1:0] acc_p1;

    assign pop_p0 = popcount(mask);

    // ---- stage p0 -> p1: accumulate ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_p1 <= '0;
        end else begin
            acc_p1 <= sat_add(acc_p1, pop_p0);
        end
    end

    assign count = acc_p1;

endmodule

// File: rtl/vx_perf_csr_reader.sv
// ---------------------------------------------------------------------------
// vx_perf_csr_reader
//   Serves CSR reads of the pipeline performance counters. Each counter is
//   zero-extended to 64 bits and exposed as two 32-bit CSRs: 0xB00+idx (low
//   word) and 0xB80+idx (high word). Two of the counters, active and stalled
//   warp-cycles, are accumulated here from per-cycle warp masks.
//
//   Reading the low word snapshots the high word of the same counter, so a
//   lo-then-hi read pair returns a coherent 64-bit value even if the counter
//   carries between the two reads. A hi read of the snapped index consumes
//   the snapshot; any other hi read returns the live upper bits. The most
//   recent lo read always owns the snapshot.
//
//   Unmapped indices and addresses outside both windows read as zero with a
//   normal handshake. Responses arrive one cycle after acceptance; only one
//   request is outstanding at a time.
//
//   Ports:
//     clk               in   1      clock
//     reset             in   1      asynchronous active-low reset
//     perf_pipeline_if  in   slave  pipeline counters and warp masks
//     req_valid         in   1      read request valid
//     req_ready         out  1      request accepted (high only when idle)
//     req_addr          in   12     CSR address
//     rsp_valid         out  1      response valid
//     rsp_ready         in   1      response consumed
//     rsp_data          out  XLEN   read data (XLEN must be 32)
// ---------------------------------------------------------------------------
module vx_perf_csr_reader
    import vx_perf_csr_reader_pkg::*;
#(
    parameter int CTR_W     = 44,
    parameter int XLEN      = 32,
    parameter int NUM_EX    = 3,
    parameter int NUM_SFU   = 2,
    parameter int NUM_WARPS = 4
) (
    input  logic                clk,
    input  logic                reset,
    vx_perf_pipeline_if.slave   perf_pipeline_if,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [11:0]         req_addr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [XLEN-1:0]     rsp_data
);

    localparam int IDX_SFU_BASE  = IDX_UNITS_BASE + NUM_EX;
    localparam int IDX_TAIL_BASE = IDX_SFU_BASE + NUM_SFU;

    function automatic logic [63:0] zext64(input logic [CTR_W-1:0] v);
        return 64'(v);
    endfunction

    logic [CTR_W-1:0] active_warp_cycles;
    logic [CTR_W-1:0] stalled_warp_cycles;

    vx_perf_accum #(
        .CTR_W     (CTR_W),
        .NUM_WARPS (NUM_WARPS)
    ) u_active_accum (
        .clk   (clk),
        .rst_n (reset),
        .mask  (perf_pipeline_if.active_warps_n),
        .count (active_warp_cycles)
    );

    vx_perf_accum #(
        .CTR_W     (CTR_W),
        .NUM_WARPS (NUM_WARPS)
    ) u_stalled_accum (
        .clk   (clk),
        .rst_n (reset),
        .mask  (perf_pipeline_if.stalled_warps_n),
        .count (stalled_warp_cycles)
    );

    csr_state_e       state_p1;
    csr_state_e       state_d;
    logic             req_fire;

    csr_win_e         req_win;
    logic [IDX_W-1:0] req_idx;
    logic [63:0]      ctr_sel;
    logic             snap_hit;
    logic [XLEN-1:0]  rd_data;

    logic [XLEN-1:0]  rsp_data_p1;
    logic [31:0]      hi_snap_p1;
    logic [IDX_W-1:0] snap_idx_p1;
    logic             snap_vld_p1;

    // Counter select: index decode is independent of the window, so the lo
    // and hi halves always come from the same 64-bit value.
    always_comb begin
        req_win = csr_window(req_addr);
        req_idx = req_addr[IDX_W-1:0];
        ctr_sel = '0;

        case (int'(req_idx))
            IDX_SCHED_IDLES:                         ctr_sel = zext64(perf_pipeline_if.sched_idles);
            IDX_SCHED_STALLS:                        ctr_sel = zext64(perf_pipeline_if.sched_stalls);
            IDX_IBF_STALLS:                          ctr_sel = zext64(perf_pipeline_if.ibf_stalls);
            IDX_SCB_STALLS:                          ctr_sel = zext64(perf_pipeline_if.scb_stalls);
            IDX_TAIL_BASE + OFS_IFETCHES:            ctr_sel = zext64(perf_pipeline_if.ifetches);
            IDX_TAIL_BASE + OFS_LOADS:               ctr_sel = zext64(perf_pipeline_if.loads);
            IDX_TAIL_BASE + OFS_STORES:              ctr_sel = zext64(perf_pipeline_if.stores);
            IDX_TAIL_BASE + OFS_IFETCH_LATENCY:      ctr_sel = zext64(perf_pipeline_if.ifetch_latency);
            IDX_TAIL_BASE + OFS_LOAD_LATENCY:        ctr_sel = zext64(perf_pipeline_if.load_latency);
            IDX_TAIL_BASE + OFS_ACTIVE_WARP_CYCLES:  ctr_sel = zext64(active_warp_cycles);
            IDX_TAIL_BASE + OFS_STALLED_WARP_CYCLES: ctr_sel = zext64(stalled_warp_cycles);
            default:                                 ctr_sel = '0;
        endcase

        for (int i = 0; i < NUM_EX; i++) begin
            if (int'(req_idx) == IDX_UNITS_BASE + i) begin
                ctr_sel = zext64(perf_pipeline_if.units_uses[i]);
            end
        end

        for (int i = 0; i < NUM_SFU; i++) begin
            if (int'(req_idx) == IDX_SFU_BASE + i) begin
                ctr_sel = zext64(perf_pipeline_if.sfu_uses[i]);
            end
        end
    end

    assign snap_hit = snap_vld_p1 && (snap_idx_p1 == req_idx);

    always_comb begin
        rd_data = '0;
        case (req_win)
            WIN_LO:  rd_data = XLEN'(ctr_sel[31:0]);
            WIN_HI:  rd_data = snap_hit ? XLEN'(hi_snap_p1) : XLEN'(ctr_sel[63:32]);
            default: rd_data = '0;
        endcase
    end

    // Response FSM: one request in flight; ready only while idle.
    always_comb begin
        state_d   = state_p1;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_p1)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_fire = req_valid && req_ready;

    // ---- stage p0 -> p1: request accept, response and snapshot registers ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_p1 <= IDLE;
        end else begin
            state_p1 <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_data_p1 <= '0;
            hi_snap_p1  <= '0;
            snap_idx_p1 <= '0;
            snap_vld_p1 <= 1'b0;
        end else if (req_fire) begin
            rsp_data_p1 <= rd_data;
            if (req_win == WIN_LO) begin
                hi_snap_p1  <= ctr_sel[63:32];
                snap_idx_p1 <= req_idx;
                snap_vld_p1 <= 1'b1;
            end else if ((req_win == WIN_HI) && snap_hit) begin
                snap_vld_p1 <= 1'b0;
            end
        end
    end

    assign rsp_data = rsp_data_p1;

endmodule

// File: tb/tb_vx_perf_csr_reader.sv
`timescale 1ns/1ps
module tb_vx_perf_csr_reader;

    localparam int CTR_W     = 44;
    localparam int NUM_EX    = 3;
    localparam int NUM_SFU   = 2;
    localparam int NUM_WARPS = 4;
    localparam int SAT_W     = 8;
    localparam logic [63:0] MAX_MAIN = (64'd1 << CTR_W) - 64'd1;
    localparam logic [63:0] MAX_SAT  = (64'd1 << SAT_W) - 64'd1;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;

    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [11:0] req_addr  = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;

    logic        req_valid8 = 1'b0;
    logic        req_ready8;
    logic [11:0] req_addr8  = '0;
    logic        rsp_valid8;
    logic        rsp_ready8 = 1'b1;
    logic [31:0] rsp_data8;

    vx_perf_pipeline_if #(.CTR_W(CTR_W), .NUM_EX(NUM_EX), .NUM_SFU(NUM_SFU), .NUM_WARPS(NUM_WARPS)) pif ();
    vx_perf_pipeline_if #(.CTR_W(SAT_W), .NUM_EX(NUM_EX), .NUM_SFU(NUM_SFU), .NUM_WARPS(NUM_WARPS)) pif8 ();

    vx_perf_csr_reader #(
        .CTR_W(CTR_W), .XLEN(32), .NUM_EX(NUM_EX), .NUM_SFU(NUM_SFU), .NUM_WARPS(NUM_WARPS)
    ) dut (
        .clk(clk), .reset(rst_n), .perf_pipeline_if(pif),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data)
    );

    // Narrow-counter instance so saturation is reachable in a short run.
    vx_perf_csr_reader #(
        .CTR_W(SAT_W), .XLEN(32), .NUM_EX(NUM_EX), .NUM_SFU(NUM_SFU), .NUM_WARPS(NUM_WARPS)
    ) dut_sat (
        .clk(clk), .reset(rst_n), .perf_pipeline_if(pif8),
        .req_valid(req_valid8), .req_ready(req_ready8), .req_addr(req_addr8),
        .rsp_valid(rsp_valid8), .rsp_ready(rsp_ready8), .rsp_data(rsp_data8)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [63:0] m_act, m_stall, m_act8, m_stall8;
    logic        ref_sval = 1'b0;
    logic [6:0]  ref_sidx = '0;
    logic [31:0] ref_hi   = '0;

    function automatic logic [63:0] sat_sum(input logic [63:0] a, input int p, input logic [63:0] mx);
        logic [63:0] s;
        s = a + 64'(p);
        return (s > mx) ? mx : s;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act <= '0; m_stall <= '0; m_act8 <= '0; m_stall8 <= '0;
        end else begin
            m_act    <= sat_sum(m_act,    $countones(pif.active_warps_n),   MAX_MAIN);
            m_stall  <= sat_sum(m_stall,  $countones(pif.stalled_warps_n),  MAX_MAIN);
            m_act8   <= sat_sum(m_act8,   $countones(pif8.active_warps_n),  MAX_SAT);
            m_stall8 <= sat_sum(m_stall8, $countones(pif8.stalled_warps_n), MAX_SAT);
        end
    end

    // 64-bit value of counter idx in the default configuration.
    function automatic logic [63:0] ref_ctr(input int idx);
        logic [63:0] v;
        v = '0;
        case (idx)
            3:  v = 64'(pif.sched_idles);
            4:  v = 64'(pif.sched_stalls);
            5:  v = 64'(pif.ibf_stalls);
            6:  v = 64'(pif.scb_stalls);
            7, 8, 9: v = 64'(pif.units_uses[idx-7]);
            10, 11:  v = 64'(pif.sfu_uses[idx-10]);
            12: v = 64'(pif.ifetches);
            13: v = 64'(pif.loads);
            14: v = 64'(pif.stores);
            15: v = 64'(pif.ifetch_latency);
            16: v = 64'(pif.load_latency);
            17: v = m_act;
            18: v = m_stall;
            default: v = '0;
        endcase
        return v;
    endfunction

    // Expected data for an accepted read; updates the model snapshot.
    function automatic logic [31:0] ref_read(input logic [11:0] addr);
        logic [63:0] v;
        logic [6:0]  idx;
        idx = addr[6:0];
        v   = ref_ctr(int'(idx));
        if (addr >= 12'hB00 && addr < 12'hB80) begin
            ref_hi   = v[63:32];
            ref_sidx = idx;
            ref_sval = 1'b1;
            return v[31:0];
        end else if (addr >= 12'hB80 && addr <= 12'hBFF) begin
            if (ref_sval && ref_sidx == idx) begin
                ref_sval = 1'b0;
                return ref_hi;
            end
            return v[63:32];
        end
        return 32'h0;
    endfunction

    function automatic logic [CTR_W-1:0] rand_ctr();
        return CTR_W'({$urandom(), $urandom()});
    endfunction

    task automatic randomize_ctrs();
        pif.sched_idles    = rand_ctr();
        pif.sched_stalls   = rand_ctr();
        pif.ibf_stalls     = rand_ctr();
        pif.scb_stalls     = rand_ctr();
        for (int i = 0; i < NUM_EX; i++)  pif.units_uses[i] = rand_ctr();
        for (int i = 0; i < NUM_SFU; i++) pif.sfu_uses[i]   = rand_ctr();
        pif.ifetches       = rand_ctr();
        pif.loads          = rand_ctr();
        pif.stores         = rand_ctr();
        pif.ifetch_latency = rand_ctr();
        pif.load_latency   = rand_ctr();
    endtask

    task automatic csr_read(input logic [11:0] addr, output logic [31:0] got,
                            output logic [31:0] exp, output int waits);
        int n;
        n = 0;
        @(negedge clk);
        req_addr  = addr;
        req_valid = 1'b1;
        while (req_ready !== 1'b1 && n < 16) begin @(negedge clk); n++; end
        exp = ref_read(addr);
        @(negedge clk);
        req_valid = 1'b0;
        while (rsp_valid !== 1'b1 && n < 32) begin @(negedge clk); n++; end
        got   = rsp_data;
        waits = n;
    endtask

    task automatic csr_read8(input logic [11:0] addr, output logic [31:0] got,
                             output logic [63:0] exp_act, output logic [63:0] exp_stall,
                             output int waits);
        int n;
        n = 0;
        @(negedge clk);
        req_addr8  = addr;
        req_valid8 = 1'b1;
        while (req_ready8 !== 1'b1 && n < 16) begin @(negedge clk); n++; end
        exp_act   = m_act8;
        exp_stall = m_stall8;
        @(negedge clk);
        req_valid8 = 1'b0;
        while (rsp_valid8 !== 1'b1 && n < 32) begin @(negedge clk); n++; end
        got   = rsp_data8;
        waits = n;
    endtask

    task automatic test_reset();
        logic [31:0] got, exp;
        int w;
        rst_n = 1'b0;
        randomize_ctrs();
        pif.active_warps_n  = '0; pif.stalled_warps_n  = '0;
        pif8.active_warps_n = '0; pif8.stalled_warps_n = '0;
        pif8.sched_idles = '0; pif8.sched_stalls = '0; pif8.ibf_stalls = '0; pif8.scb_stalls = '0;
        pif8.units_uses = '0; pif8.sfu_uses = '0; pif8.ifetches = '0; pif8.loads = '0;
        pif8.stores = '0; pif8.ifetch_latency = '0; pif8.load_latency = '0;
        repeat (3) @(negedge clk);
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        n_tests++; if (rsp_data !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); end
        rst_n = 1'b1; ref_sval = 1'b0;
        @(negedge clk);
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        csr_read(12'hB11, got, exp, w);
        n_tests++; if (got !== 32'h0 || got !== exp) begin n_fail++; $display("FAIL reset_accum_zero: got %h expected %h", got, exp); end
    endtask

    task automatic test_split_read();
        logic [31:0] got, exp;
        int w;
        pif.sched_idles = 44'h0A_1234_5678;
        csr_read(12'hB03, got, exp, w);
        n_tests++; if (got !== 32'h1234_5678 || got !== exp) begin n_fail++; $display("FAIL split_lo: got %h expected 12345678", got); end
        n_tests++; if (w !== 0) begin n_fail++; $display("FAIL split_latency: got %0d extra cycles expected 0", w); end
        csr_read(12'hB83, got, exp, w);
        n_tests++; if (got !== 32'h0000_000A || got !== exp) begin n_fail++; $display("FAIL split_hi: got %h expected 0000000a", got); end
    endtask

    task automatic test_snapshot();
        logic [31:0] got, exp;
        int w;
        pif.sched_stalls = 44'h5_FFFF_FFFE;
        csr_read(12'hB04, got, exp, w);
        n_tests++; if (got !== 32'hFFFF_FFFE || got !== exp) begin n_fail++; $display("FAIL snap_lo: got %h expected fffffffe", got); end
        pif.sched_stalls = 44'h6_0000_0003;
        csr_read(12'hB84, got, exp, w);
        n_tests++; if (got !== 32'h5 || got !== exp) begin n_fail++; $display("FAIL snap_hi_held: got %h expected 5", got); end
        csr_read(12'hB84, got, exp, w);
        n_tests++; if (got !== 32'h6 || got !== exp) begin n_fail++; $display("FAIL snap_hi_live: got %h expected 6", got); end
        // last lo wins
        pif.ibf_stalls = 44'h1_0000_0000;
        csr_read(12'hB04, got, exp, w);
        csr_read(12'hB05, got, exp, w);
        pif.sched_stalls = 44'h7_0000_0000;
        pif.ibf_stalls   = 44'h2_0000_0000;
        csr_read(12'hB84, got, exp, w);
        n_tests++; if (got !== 32'h7 || got !== exp) begin n_fail++; $display("FAIL snap_overwritten: got %h expected 7", got); end
        csr_read(12'hB85, got, exp, w);
        n_tests++; if (got !== 32'h1 || got !== exp) begin n_fail++; $display("FAIL snap_last_lo: got %h expected 1", got); end
        csr_read(12'hB85, got, exp, w);
        n_tests++; if (got !== 32'h2 || got !== exp) begin n_fail++; $display("FAIL snap_consumed: got %h expected 2", got); end
    endtask

    task automatic test_warp_count();
        logic [31:0] got, exp;
        int w;
        @(negedge clk);
        rst_n = 1'b0;
        pif.active_warps_n  = 4'b1011;
        pif.stalled_warps_n = 4'b0101;
        repeat (2) @(negedge clk);
        rst_n = 1'b1; ref_sval = 1'b0;
        repeat (10) @(negedge clk);
        pif.active_warps_n  = '0;
        pif.stalled_warps_n = '0;
        csr_read(12'hB11, got, exp, w);
        n_tests++; if (got !== 32'd30 || got !== exp) begin n_fail++; $display("FAIL warp_active: got %0d expected 30", got); end
        csr_read(12'hB12, got, exp, w);
        n_tests++; if (got !== 32'd20 || got !== exp) begin n_fail++; $display("FAIL warp_stalled: got %0d expected 20", got); end
        csr_read(12'hB91, got, exp, w);
        n_tests++; if (got !== 32'h0 || got !== exp) begin n_fail++; $display("FAIL warp_active_hi: got %h expected 0", got); end
    endtask

    task automatic test_unmapped();
        logic [31:0] got, exp;
        logic [11:0] addrs [11];
        int w;
        addrs = '{12'hB1F, 12'h300, 12'hB00, 12'hB02, 12'hB13, 12'hB9F,
                  12'hBFF, 12'h000, 12'hFFF, 12'hC00, 12'hAFF};
        randomize_ctrs();
        for (int i = 0; i < 11; i++) begin
            csr_read(addrs[i], got, exp, w);
            n_tests++;
            if (got !== 32'h0 || got !== exp || w !== 0) begin
                n_fail++;
                $display("FAIL unmapped_%h: got %h after %0d extra cycles expected 0 after 0", addrs[i], got, w);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] got, exp;
        logic [11:0] addr;
        logic [6:0]  last_lo;
        bit          have_lo;
        int          r, w;
        have_lo = 1'b0; last_lo = '0;
        for (int it = 0; it < 60; it++) begin
            randomize_ctrs();
            pif.active_warps_n  = 4'($urandom_range(0, 15));
            pif.stalled_warps_n = 4'($urandom_range(0, 15));
            r = $urandom_range(0, 9);
            if (r < 3 && have_lo) addr = 12'hB80 + 12'(last_lo);
            else if (r < 6) begin
                last_lo = 7'($urandom_range(0, 20)); have_lo = 1'b1;
                addr = 12'hB00 + 12'(last_lo);
            end else if (r < 8) addr = 12'hB80 + 12'($urandom_range(0, 20));
            else addr = 12'($urandom_range(0, 4095));
            csr_read(addr, got, exp, w);
            n_tests++;
            if (got !== exp || w !== 0) begin
                n_fail++;
                $display("FAIL random_%h: got %h after %0d extra cycles expected %h after 0", addr, got, w, exp);
            end
            n_tests++;
            if (req_ready !== 1'b0) begin n_fail++; $display("FAIL random_busy_ready: got %b expected 0", req_ready); end
        end
        pif.active_warps_n = '0; pif.stalled_warps_n = '0;
    endtask

    task automatic test_back_to_back();
        logic [11:0] addrs [5];
        logic [31:0] exp;
        addrs = '{12'hB0C, 12'hB8C, 12'hB07, 12'hB11, 12'hB87};
        exp = '0;
        randomize_ctrs();
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            n_tests++;
            if (k % 2 == 0) begin
                if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
                    n_fail++; $display("FAIL b2b_idle_%0d: got valid %b ready %b expected 0 1", k, rsp_valid, req_ready);
                end
                req_addr = addrs[k/2]; req_valid = 1'b1;
                exp = ref_read(addrs[k/2]);
            end else begin
                if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_data !== exp) begin
                    n_fail++; $display("FAIL b2b_resp_%0d: got valid %b ready %b data %h expected 1 0 %h", k, rsp_valid, req_ready, rsp_data, exp);
                end
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
    endtask

    task automatic test_hold();
        logic [31:0] got, exp;
        int w;
        pif.sched_stalls = 44'h7_1111_2222;
        rsp_ready = 1'b0;
        csr_read(12'hB04, got, exp, w);
        n_tests++; if (got !== 32'h1111_2222 || got !== exp || w !== 0) begin n_fail++; $display("FAIL hold_first: got %h expected 11112222", got); end
        for (int i = 0; i < 5; i++) begin
            pif.sched_stalls = rand_ctr();
            @(negedge clk);
            n_tests++;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'h1111_2222 || req_ready !== 1'b0) begin
                n_fail++; $display("FAIL hold_%0d: got valid %b data %h ready %b expected 1 11112222 0", i, rsp_valid, rsp_data, req_ready);
            end
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++; if (rsp_valid !== 1'b0 || rsp_data !== 32'h0) begin n_fail++; $display("FAIL reset_mid_resp: got valid %b data %h expected 0 0", rsp_valid, rsp_data); end
        rst_n = 1'b1; ref_sval = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL dropped_rsp: got %b expected 0", rsp_valid); end
        pif.sched_stalls = 44'h8_0000_0001;
        csr_read(12'hB84, got, exp, w);
        n_tests++; if (got !== 32'h8 || got !== exp) begin n_fail++; $display("FAIL snap_reset: got %h expected 8", got); end
    endtask

    task automatic test_saturation();
        logic [31:0] got;
        logic [63:0] ea, es;
        int w;
        for (int i = 0; i < 6; i++) begin
            pif8.active_warps_n  = 4'($urandom_range(0, 15));
            pif8.stalled_warps_n = 4'($urandom_range(0, 15));
            repeat (8) @(negedge clk);
            csr_read8((i % 2 == 0) ? 12'hB11 : 12'hB12, got, ea, es, w);
            n_tests++;
            if (got !== ((i % 2 == 0) ? ea[31:0] : es[31:0]) || w !== 0) begin
                n_fail++; $display("FAIL sat_partial_%0d: got %0d expected act %0d stall %0d", i, got, ea, es);
            end
        end
        pif8.active_warps_n  = 4'b1111;
        pif8.stalled_warps_n = 4'b1111;
        repeat (70) @(negedge clk);
        for (int j = 0; j < 2; j++) begin
            csr_read8(12'hB11, got, ea, es, w);
            n_tests++; if (got !== 32'hFF || got !== ea[31:0]) begin n_fail++; $display("FAIL sat_active_%0d: got %0d expected 255", j, got); end
            csr_read8(12'hB12, got, ea, es, w);
            n_tests++; if (got !== 32'hFF || got !== es[31:0]) begin n_fail++; $display("FAIL sat_stalled_%0d: got %0d expected 255", j, got); end
            repeat (20) @(negedge clk);
        end
        csr_read8(12'hB91, got, ea, es, w);
        n_tests++; if (got !== 32'h0) begin n_fail++; $display("FAIL sat_hi_zext: got %h expected 0", got); end
    endtask

    initial begin
        test_reset();
        test_split_read();
        test_snapshot();
        test_warp_count();
        test_unmapped();
        test_random();
        test_back_to_back();
        test_hold();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
